// File: rtl/branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared constants for the branch resolve unit:
//   - funct3-style branch codes carried in SELECT[2:0] (SELECT[3] marks a
//     control-flow op),
//   - 2-bit bimodal counter values used by the branch history table.
// ---------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    // Branch / jump codes (SELECT[2:0]); 3'b011 is a defined not-taken slot.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_JMP  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Bimodal counter encoding: MSB is the predicted direction.
    localparam logic [1:0] CTR_INIT = 2'b01;
    localparam logic [1:0] CTR_MAX  = 2'b11;
    localparam logic [1:0] CTR_MIN  = 2'b00;

    // Conditional branches train the predictor; jumps and the 011 slot do not.
    function automatic logic is_cond_branch(input logic [2:0] code);
        return (code == BR_BEQ) || (code == BR_BNE) || code[2];
    endfunction

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// ---------------------------------------------------------------------------
// branch_compare
// Purely combinational branch direction evaluation.
//   data1, data2 : rs1 / rs2 operands (XLEN bits)
//   select       : [3] control-flow op, [2:0] branch code
//   taken        : resolved direction (0 whenever select[3] = 0)
// ---------------------------------------------------------------------------
module branch_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [3:0]      select,
    output logic            taken
);

    logic signed [XLEN-1:0] data1_s;
    logic signed [XLEN-1:0] data2_s;
    logic                   lt_s;
    logic                   lt_u;

    assign data1_s = data1;
    assign data2_s = data2;
    assign lt_s    = data1_s < data2_s;
    assign lt_u    = data1 < data2;

    always_comb begin
        taken = 1'b0;
        if (select[3]) begin
            case (select[2:0])
                BR_BEQ:  taken = (data1 == data2);
                BR_BNE:  taken = (data1 != data2);
                BR_JMP:  taken = 1'b1;
                BR_BLT:  taken = lt_s;
                BR_BGE:  taken = ~lt_s;
                BR_BLTU: taken = lt_u;
                BR_BGEU: taken = ~lt_u;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Registered branch resolution (1-cycle latency) with a bimodal BHT of 2-bit
// saturating counters and a saturating mispredict performance counter.
// Ports:
//   CLK, RESET_N        : clock (rising edge), async active-low reset
//   FETCH_PC / PRED_TAKEN : fetch lookup, combinational counter MSB
//   RES_VALID, RES_PC, DATA1, DATA2, SELECT, RES_PRED_TAKEN : resolve inputs
//   STALL, FLUSH        : STALL holds all state; FLUSH kills the resolve op
//   OUT_VALID, BRANCH_TAKEN, MISPREDICT : registered results
//   MISPREDICT_COUNT    : saturating mispredict count (CNT_W bits)
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [XLEN-1:0]  FETCH_PC,
    output logic             PRED_TAKEN,
    input  logic             RES_VALID,
    input  logic [XLEN-1:0]  RES_PC,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [3:0]       SELECT,
    input  logic             RES_PRED_TAKEN,
    input  logic             STALL,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    output logic             BRANCH_TAKEN,
    output logic             MISPREDICT,
    output logic [CNT_W-1:0] MISPREDICT_COUNT
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX-1:0]   fetch_idx;
    logic [IDX-1:0]   res_idx;
    logic             taken_p0;
    logic             live_p0;
    logic             mp_p0;
    logic             bht_upd_p0;

    logic             vld_p1;
    logic             taken_p1;
    logic             mp_p1;
    logic [CNT_W-1:0] mp_cnt_p1;

    // PC bits outside the index field do not participate in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{FETCH_PC[XLEN-1:IDX+2], FETCH_PC[1:0],
                              RES_PC[XLEN-1:IDX+2], RES_PC[1:0]};

    assign fetch_idx  = FETCH_PC[IDX+1:2];
    assign res_idx    = RES_PC[IDX+1:2];
    // No bypass: a same-cycle update to this index shows up after the edge.
    assign PRED_TAKEN = bht[fetch_idx][1];

    // ---- stage p0: combinational resolve ----
    branch_compare #(.XLEN(XLEN)) u_compare (
        .data1  (DATA1),
        .data2  (DATA2),
        .select (SELECT),
        .taken  (taken_p0)
    );

    assign live_p0    = RES_VALID & ~FLUSH;
    assign mp_p0      = live_p0 & SELECT[3] & (taken_p0 != RES_PRED_TAKEN);
    assign bht_upd_p0 = live_p0 & ~STALL & SELECT[3] & is_cond_branch(SELECT[2:0]);

    // ---- stage p1: registered results, BHT and perf counter ----
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_p1    <= 1'b0;
            taken_p1  <= 1'b0;
            mp_p1     <= 1'b0;
            mp_cnt_p1 <= '0;
        end else if (!STALL) begin
            vld_p1   <= live_p0;
            taken_p1 <= taken_p0;
            mp_p1    <= mp_p0;
            if (mp_p0)
                mp_cnt_p1 <= cnt_sat_inc(mp_cnt_p1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CTR_INIT;
        end else if (bht_upd_p0) begin
            bht[res_idx] <= ctr_next(bht[res_idx], taken_p0);
        end
    end

    assign OUT_VALID        = vld_p1;
    assign BRANCH_TAKEN     = taken_p1;
    assign MISPREDICT       = mp_p1;
    assign MISPREDICT_COUNT = mp_cnt_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Two instances share one stimulus stream: dut_a with default parameters and
// dut_b with a 2-bit mispredict counter. A behavioural model tracks expected
// outputs; a negedge process compares every cycle, and directed checks with
// hand-computed constants pin the model.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] FETCH_PC = '0;
    logic        RES_VALID = 1'b0;
    logic [31:0] RES_PC = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [3:0]  SELECT = '0;
    logic        RES_PRED_TAKEN = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;

    logic        a_pred, a_ov, a_bt, a_mp;
    logic [15:0] a_cnt;
    logic        b_pred, b_ov, b_bt, b_mp;
    logic [1:0]  b_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 CLK = ~CLK;

    branch_resolve_unit dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .FETCH_PC(FETCH_PC), .PRED_TAKEN(a_pred),
        .RES_VALID(RES_VALID), .RES_PC(RES_PC), .DATA1(DATA1), .DATA2(DATA2),
        .SELECT(SELECT), .RES_PRED_TAKEN(RES_PRED_TAKEN), .STALL(STALL), .FLUSH(FLUSH),
        .OUT_VALID(a_ov), .BRANCH_TAKEN(a_bt), .MISPREDICT(a_mp), .MISPREDICT_COUNT(a_cnt)
    );

    branch_resolve_unit #(.CNT_W(2)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .FETCH_PC(FETCH_PC), .PRED_TAKEN(b_pred),
        .RES_VALID(RES_VALID), .RES_PC(RES_PC), .DATA1(DATA1), .DATA2(DATA2),
        .SELECT(SELECT), .RES_PRED_TAKEN(RES_PRED_TAKEN), .STALL(STALL), .FLUSH(FLUSH),
        .OUT_VALID(b_ov), .BRANCH_TAKEN(b_bt), .MISPREDICT(b_mp), .MISPREDICT_COUNT(b_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_taken(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel[3]) return 1'b0;
        case (sel[2:0])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return 1'b1;
            3'd3: return 1'b0;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic int bht_index(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    int  m_bht [16];
    bit  m_ov, m_bt, m_mp;
    int  m_cnt_a, m_cnt_b;
    bit  m_t, m_live, m_mis, m_train;
    int  m_ridx;

    always_comb begin
        m_t     = model_taken(SELECT, DATA1, DATA2);
        m_live  = RES_VALID && !FLUSH;
        m_mis   = m_live && SELECT[3] && (m_t != RES_PRED_TAKEN);
        m_train = m_live && SELECT[3] && (SELECT[2:0] == 3'd0 || SELECT[2:0] == 3'd1 || SELECT[2]);
        m_ridx  = bht_index(RES_PC);
    end

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_ov <= 0; m_bt <= 0; m_mp <= 0;
            m_cnt_a <= 0; m_cnt_b <= 0;
            for (int i = 0; i < 16; i++) m_bht[i] <= 1;
        end else if (!STALL) begin
            m_ov <= m_live;
            m_bt <= m_t;
            m_mp <= m_mis;
            if (m_mis) begin
                m_cnt_a <= (m_cnt_a >= 65535) ? 65535 : m_cnt_a + 1;
                m_cnt_b <= (m_cnt_b >= 3) ? 3 : m_cnt_b + 1;
            end
            if (m_train)
                m_bht[m_ridx] <= m_t ? ((m_bht[m_ridx] >= 3) ? 3 : m_bht[m_ridx] + 1)
                                     : ((m_bht[m_ridx] <= 0) ? 0 : m_bht[m_ridx] - 1);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            check("a_out_valid", {31'b0, a_ov}, {31'b0, m_ov});
            check("a_mispredict", {31'b0, a_mp}, {31'b0, m_mp});
            if (m_ov) check("a_branch_taken", {31'b0, a_bt}, {31'b0, m_bt});
            check("a_count", {16'b0, a_cnt}, m_cnt_a);
            check("a_pred_taken", {31'b0, a_pred}, {31'b0, m_bht[bht_index(FETCH_PC)] >= 2});
            check("b_mispredict", {31'b0, b_mp}, {31'b0, m_mp});
            check("b_count", {30'b0, b_cnt}, m_cnt_b);
            check("b_pred_taken", {31'b0, b_pred}, {31'b0, m_bht[bht_index(FETCH_PC)] >= 2});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [3:0] sel, input logic pred);
        RES_VALID = v; RES_PC = pc; DATA1 = d1; DATA2 = d2; SELECT = sel; RES_PRED_TAKEN = pred;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic bt, input logic mp,
                              input int cnt_a, input int cnt_b);
        check({tag, "_ov"}, {31'b0, a_ov}, {31'b0, ov});
        if (ov) check({tag, "_bt"}, {31'b0, a_bt}, {31'b0, bt});
        check({tag, "_mp"}, {31'b0, a_mp}, {31'b0, mp});
        check({tag, "_cnt_a"}, {16'b0, a_cnt}, cnt_a);
        check({tag, "_cnt_b"}, {30'b0, b_cnt}, cnt_b);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  sel;
        logic        pred;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h40; pcs[3] = 32'h3C;

        tbl[0] = '{32'h200, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1100, 1'b1}; // BLT  taken
        tbl[1] = '{32'h204, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1111, 1'b0}; // BGEU taken
        tbl[2] = '{32'h208, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1101, 1'b0}; // BGE  not
        tbl[3] = '{32'h20C, 32'h0000_0003, 32'h0000_0003, 4'b1101, 1'b1}; // BGE  equal
        tbl[4] = '{32'h210, 32'h0000_0003, 32'h0000_0003, 4'b1110, 1'b0}; // BLTU equal
        tbl[5] = '{32'h214, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'b1100, 1'b0}; // BLT  -2<-1
        tbl[6] = '{32'h218, 32'h1234_5678, 32'h1234_5679, 4'b1001, 1'b1}; // BNE
        tbl[7] = '{32'h21C, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b1}; // BGEU not

        // Reset
        issue(0, 0, 0, 0, 4'b0000, 0);
        tick(); tick();
        RESET_N = 1'b1;
        expect_out("reset", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            FETCH_PC = pcs[i];
            #1;
            check("reset_pred", {31'b0, a_pred}, 32'd0);
        end
        chk_en = 1;

        // Signed vs unsigned on the same operands
        issue(1, 32'h104, 32'hFFFF_FFFF, 32'h1, 4'b1100, 1);
        tick(); expect_out("blt", 1, 1, 0, 0, 0);
        issue(1, 32'h104, 32'hFFFF_FFFF, 32'h1, 4'b1110, 0);
        tick(); expect_out("bltu", 1, 0, 0, 0, 0);

        // Counter training at 0x40
        FETCH_PC = 32'h40;
        issue(1, 32'h40, 32'd5, 32'd5, 4'b1000, 0);
        tick(); expect_out("train1", 1, 1, 1, 1, 1);
        check("train1_pred", {31'b0, a_pred}, 32'd1);
        tick(); expect_out("train2", 1, 1, 1, 2, 2);
        check("train2_pred", {31'b0, a_pred}, 32'd1);
        issue(1, 32'h40, 32'd5, 32'd5, 4'b1000, 1);
        tick(); expect_out("train3", 1, 1, 0, 2, 2);
        // Decrements from a saturated 11: 10 keeps taken, 01 flips
        issue(1, 32'h40, 32'd5, 32'd5, 4'b1001, 1);
        tick(); expect_out("untrain1", 1, 0, 1, 3, 3);
        check("untrain1_pred", {31'b0, a_pred}, 32'd1);
        tick(); expect_out("untrain2", 1, 0, 1, 4, 3);
        check("untrain2_pred", {31'b0, a_pred}, 32'd0);

        // Jumps: always taken, never train
        issue(1, 32'h40, 32'd1, 32'd2, 4'b1010, 1);
        tick(); expect_out("jmp1", 1, 1, 0, 4, 3);
        check("jmp1_pred", {31'b0, a_pred}, 32'd0);
        issue(1, 32'h40, 32'd1, 32'd2, 4'b1010, 0);
        tick(); expect_out("jmp2", 1, 1, 1, 5, 3);
        check("jmp2_pred", {31'b0, a_pred}, 32'd0);

        // Stall / flush
        FETCH_PC = 32'h48;
        issue(1, 32'h48, 32'd7, 32'd7, 4'b1000, 0);
        tick(); expect_out("pre_stall", 1, 1, 1, 6, 3);
        check("pre_stall_pred", {31'b0, a_pred}, 32'd1);
        STALL = 1;
        issue(1, 32'h48, 32'd7, 32'd7, 4'b1001, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("stall", 1, 1, 1, 6, 3);
            check("stall_pred", {31'b0, a_pred}, 32'd1);
        end
        FLUSH = 1;
        tick(); expect_out("stall_flush", 1, 1, 1, 6, 3);
        STALL = 0;
        tick(); expect_out("flush", 0, 0, 0, 6, 3);
        check("flush_pred", {31'b0, a_pred}, 32'd1);
        FLUSH = 0;

        // Non-control-flow and the 011 slot
        issue(1, 32'h48, 32'd7, 32'd7, 4'b0000, 1);
        tick(); expect_out("nonbr", 1, 0, 0, 6, 3);
        issue(1, 32'h48, 32'd7, 32'd7, 4'b1011, 0);
        tick(); expect_out("code011", 1, 0, 0, 6, 3);

        // Compare table, checked by the model
        for (int i = 0; i < 8; i++) begin
            FETCH_PC = tbl[i].pc;
            issue(1, tbl[i].pc, tbl[i].d1, tbl[i].d2, tbl[i].sel, tbl[i].pred);
            tick();
        end
        check("tbl0_blt", {31'b0, model_taken(tbl[0].sel, tbl[0].d1, tbl[0].d2)}, 32'd1);
        check("tbl2_bge", {31'b0, model_taken(tbl[2].sel, tbl[2].d1, tbl[2].d2)}, 32'd0);

        // Mid-operation asynchronous reset
        FETCH_PC = 32'h48;
        issue(1, 32'h40, 32'd9, 32'd9, 4'b1000, 0);
        tick();
        check("pre_reset_ov", {31'b0, a_ov}, 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0, 0);
        check("async_rst_pred", {31'b0, a_pred}, 32'd0);
        tick();
        RESET_N = 1'b1;
        issue(1, 32'h48, 32'd1, 32'd2, 4'b1100, 0);
        tick(); expect_out("post_rst", 1, 1, 1, 1, 1);
        issue(0, 0, 0, 0, 4'b0000, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
